// File: rtl/if_fetch_buffer_if.sv
// I-cache request/response and IF/ID handshake bundle for the fetch buffer.
// The master side is the fetch buffer itself; the slave side is the I-cache plus ID stage.
interface if_fetch_buffer_if;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_instr;
  logic [1:0]  icache_resp_exc;
  logic        ID_Wr;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;
  logic [2:0]  IF_ExceptType;

  modport master (
    output icache_req_valid, icache_req_addr,
    input  icache_req_ready, icache_resp_valid, icache_resp_instr, icache_resp_exc, ID_Wr,
    output IF_Valid, IF_Instr, IF_PC, IF_ExceptType
  );

  modport slave (
    input  icache_req_valid, icache_req_addr,
    output icache_req_ready, icache_resp_valid, icache_resp_instr, icache_resp_exc, ID_Wr,
    input  IF_Valid, IF_Instr, IF_PC, IF_ExceptType
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch producer: credit-limited sequential I-cache requests, in-order
// response FIFO towards ID, redirect flush with stale-response dropping.
module if_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  if_fetch_buffer_if.master       bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} fetch_state_t;

  fetch_state_t  state_r, state_nxt_s;
  logic [31:0]   fetch_pc_r, fetch_pc_nxt_s;
  logic [31:0]   resp_pc_r, resp_pc_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic [AW:0]   outstanding_r, outstanding_nxt_s;
  logic [AW:0]   drop_cnt_r, drop_nxt_s;
  logic [AW-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [2:0]    exc_mem_r   [DEPTH];

  logic          credit_ok_s, misaligned_s, halted_s, head_valid_s;
  logic          req_valid_s, req_fire_s, resp_push_s, exc_push_s, push_s, pop_s;
  logic [31:0]   push_instr_s, push_pc_s;
  logic [2:0]    push_exc_s;

  // Outstanding includes stale requests, so the credit also covers responses still to be dropped.
  assign credit_ok_s  = ({1'b0, count_r} + {1'b0, outstanding_r}) < {1'b0, DEPTH_C};
  assign misaligned_s = (fetch_pc_r[1:0] != 2'b00);
  assign halted_s     = (state_r == ST_HALT);
  assign head_valid_s = (count_r != CNT_ZERO);
  assign req_valid_s  = ~rst & credit_ok_s & ~redirect_valid & ~halted_s & ~misaligned_s;
  assign req_fire_s   = req_valid_s & bus.icache_req_ready;
  assign resp_push_s  = bus.icache_resp_valid & ~redirect_valid & (drop_cnt_r == CNT_ZERO);
  assign exc_push_s   = ~redirect_valid & ~halted_s & misaligned_s &
                        (outstanding_r == CNT_ZERO) & (count_r < DEPTH_C);
  assign push_s       = resp_push_s | exc_push_s;
  assign pop_s        = head_valid_s & bus.ID_Wr & ~redirect_valid;

  assign bus.icache_req_valid = req_valid_s;
  assign bus.icache_req_addr  = fetch_pc_r;
  assign bus.IF_Valid         = head_valid_s;
  assign bus.IF_Instr         = head_valid_s ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.IF_PC            = head_valid_s ? pc_mem_r[rd_ptr_r]    : 32'h0000_0000;
  assign bus.IF_ExceptType    = head_valid_s ? exc_mem_r[rd_ptr_r]   : 3'b000;

  // Next-state for fetch PC, counters, FIFO pointers, halt state and push payload.
  always_comb begin
    outstanding_nxt_s = outstanding_r + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                      - (bus.icache_resp_valid ? CNT_ONE : CNT_ZERO);
    fetch_pc_nxt_s = fetch_pc_r;
    resp_pc_nxt_s  = resp_pc_r;
    drop_nxt_s     = drop_cnt_r;
    count_nxt_s    = count_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    state_nxt_s    = state_r;
    push_instr_s   = bus.icache_resp_instr;
    push_pc_s      = resp_pc_r;
    push_exc_s     = {bus.icache_resp_exc, 1'b0};

    if (exc_push_s) begin
      push_instr_s = 32'h0000_0000;
      push_pc_s    = fetch_pc_r;
      push_exc_s   = 3'b001;
    end else begin
      push_instr_s = bus.icache_resp_instr;
    end

    if (redirect_valid) begin
      // Every request still in flight after this edge belongs to the old path.
      fetch_pc_nxt_s = redirect_pc;
      resp_pc_nxt_s  = redirect_pc;
      drop_nxt_s     = outstanding_nxt_s;
      count_nxt_s    = CNT_ZERO;
      wr_ptr_nxt_s   = PTR_ZERO;
      rd_ptr_nxt_s   = PTR_ZERO;
      state_nxt_s    = ST_RUN;
    end else begin
      fetch_pc_nxt_s = req_fire_s  ? fetch_pc_r + 32'd4 : fetch_pc_r;
      resp_pc_nxt_s  = resp_push_s ? resp_pc_r + 32'd4  : resp_pc_r;
      drop_nxt_s     = (bus.icache_resp_valid && (drop_cnt_r != CNT_ZERO)) ?
                       drop_cnt_r - CNT_ONE : drop_cnt_r;
      count_nxt_s    = count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
      wr_ptr_nxt_s   = push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_nxt_s   = pop_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      case (state_r)
        ST_RUN:  state_nxt_s = exc_push_s ? ST_HALT : ST_RUN;
        ST_HALT: state_nxt_s = ST_HALT;
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      count_r       <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
    end else begin
      state_r       <= state_nxt_s;
      fetch_pc_r    <= fetch_pc_nxt_s;
      resp_pc_r     <= resp_pc_nxt_s;
      count_r       <= count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_cnt_r    <= drop_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
    end
  end

  // FIFO entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= 32'h0000_0000;
        exc_mem_r[i]   <= 3'b000;
      end
    end else if (push_s) begin
      instr_mem_r[wr_ptr_r] <= push_instr_s;
      pc_mem_r[wr_ptr_r]    <= push_pc_s;
      exc_mem_r[wr_ptr_r]   <= push_exc_s;
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Scoreboard bench for if_fetch_buffer: directed phases push hand-computed entries,
// a monitor compares every entry ID consumes; an I-cache model answers with instr=~pc.
module tb_if_fetch_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  if_fetch_buffer_if bus();

  if_fetch_buffer #(.DEPTH(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          acc_cnt  = 0;
  logic [31:0] exc_addr = 32'hFFFF_FFFC;
  logic [31:0] resp_addr;
  exp_t        exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic [2:0] exc);
    exp_q.push_back({pc, instr, exc});
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expect_entry(base + 32'(4 * i), ~(base + 32'(4 * i)), 3'b000);
  endtask

  // I-cache model: accepts at the negedge view of a cycle, answers lat cycles later, in order.
  initial begin
    bus.icache_resp_valid = 1'b0;
    bus.icache_resp_instr = 32'h0;
    bus.icache_resp_exc   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst && bus.icache_req_valid && bus.icache_req_ready) begin
        pend_addr.push_back(bus.icache_req_addr);
        pend_due.push_back(cyc + lat);
        acc_cnt++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        resp_addr = pend_addr.pop_front();
        void'(pend_due.pop_front());
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_instr = ~resp_addr;
        bus.icache_resp_exc   = (resp_addr == exc_addr) ? 2'b01 : 2'b00;
      end else begin
        bus.icache_resp_valid = 1'b0;
      end
    end
  end

  // Monitor: every entry ID consumes must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.IF_Valid && bus.ID_Wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h exc=%b, expected no entry",
                   bus.IF_PC, bus.IF_Instr, bus.IF_ExceptType);
        end else begin
          e = exp_q.pop_front();
          if (bus.IF_PC !== e.pc || bus.IF_Instr !== e.instr || bus.IF_ExceptType !== e.exc) begin
            failures++;
            $display("FAIL sb_entry: got pc=%h instr=%h exc=%b, expected pc=%h instr=%h exc=%b",
                     bus.IF_PC, bus.IF_Instr, bus.IF_ExceptType, e.pc, e.instr, e.exc);
          end
        end
      end
    end
  end

  initial begin
    int v;
    int base;
    rst                  = 1'b1;
    redirect_valid       = 1'b0;
    redirect_pc          = 32'h0;
    bus.icache_req_ready = 1'b1;
    bus.ID_Wr            = 1'b1;

    // Reset: outputs idle while rst is held.
    repeat (3) begin
      @(negedge clk);
      check("reset_if_valid",  {31'b0, bus.IF_Valid}, 32'd0);
      check("reset_req_valid", {31'b0, bus.icache_req_valid}, 32'd0);
      check("reset_if_pc",     bus.IF_PC, 32'h0);
    end

    // Streaming: six back-to-back fetches, consumed with no gaps.
    expect_seq(32'hBFC0_0000, 6);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", {31'b0, bus.icache_req_valid}, 32'd1);
    check("first_req_addr",  bus.icache_req_addr, 32'hBFC0_0000);
    tick();
    v = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) bus.icache_req_ready = 1'b0;
      if (i >= 2 && bus.IF_Valid) v++;
      tick();
    end
    check("stream_no_gap", 32'(v), 32'd6);
    check("stream_drained", {31'b0, bus.IF_Valid}, 32'd0);

    // Backpressure: four credits, then one more per pop.
    expect_seq(32'hBFC0_0018, 5);
    bus.ID_Wr = 1'b0;
    bus.icache_req_ready = 1'b1;
    base = acc_cnt;
    repeat (10) tick();
    check("bp_accepts_full", 32'(acc_cnt - base), 32'd4);
    check("bp_if_valid", {31'b0, bus.IF_Valid}, 32'd1);
    bus.ID_Wr = 1'b1;
    tick();
    bus.ID_Wr = 1'b0;
    base = acc_cnt;
    repeat (6) tick();
    check("bp_accepts_after_pop", 32'(acc_cnt - base), 32'd1);
    bus.icache_req_ready = 1'b0;
    bus.ID_Wr = 1'b1;
    repeat (6) tick();
    check("bp_drained", {31'b0, bus.IF_Valid}, 32'd0);

    // Stale drop: two requests in flight at redirect are discarded.
    lat = 3;
    expect_entry(32'h8000_1000, ~32'h8000_1000, 3'b000);
    bus.icache_req_ready = 1'b1;
    tick();
    tick();
    bus.icache_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    v = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        redirect_valid = 1'b0;
        bus.icache_req_ready = 1'b1;
      end
      if (i == 2) bus.icache_req_ready = 1'b0;
      if (bus.IF_Valid) v++;
      tick();
    end
    check("stale_no_valid", 32'(v), 32'd0);
    check("stale_new_valid", {31'b0, bus.IF_Valid}, 32'd1);
    repeat (3) tick();

    // Misaligned redirect: one AdEL entry, then no requests until a new redirect.
    lat = 1;
    expect_entry(32'h8000_0002, 32'h0, 3'b001);
    bus.icache_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    base = acc_cnt;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    check("misaligned_no_req", 32'(acc_cnt - base), 32'd0);
    expect_seq(32'h8000_0000, 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0000;
    tick();
    redirect_valid = 1'b0;
    base = acc_cnt;
    tick();
    tick();
    bus.icache_req_ready = 1'b0;
    repeat (4) tick();
    check("resume_accepts", 32'(acc_cnt - base), 32'd2);

    // Cache exception: flagged in IF_ExceptType, fetch carries on.
    exc_addr = 32'h8000_0008;
    expect_entry(32'h8000_0008, ~32'h8000_0008, 3'b010);
    expect_seq(32'h8000_000C, 2);
    bus.icache_req_ready = 1'b1;
    repeat (3) tick();
    bus.icache_req_ready = 1'b0;
    repeat (4) tick();

    // Redirect colliding with a response: that response and the one behind it are dropped.
    lat = 2;
    expect_entry(32'h8000_2000, ~32'h8000_2000, 3'b000);
    bus.icache_req_ready = 1'b1;
    tick();
    tick();
    bus.icache_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        redirect_valid = 1'b0;
        bus.icache_req_ready = 1'b1;
      end
      if (i == 2) bus.icache_req_ready = 1'b0;
      if (bus.IF_Valid) v++;
      tick();
    end
    check("collide_no_valid", 32'(v), 32'd0);
    check("collide_new_valid", {31'b0, bus.IF_Valid}, 32'd1);

    bus.ID_Wr = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
Instruction-fetch producer for the IF/ID boundary. It owns the fetch PC, issues sequential fetch requests to the I-cache under a credit limit, and buffers in-order responses in a small FIFO. It presents IF_Instr, IF_PC and IF_ExceptType to the ID stage, which consumes entries with ID_Wr. Redirects from later stages flush the FIFO and discard stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries and also the maximum of (FIFO occupancy + outstanding requests); power of 2, ≥2.
RESET_PC, 32'hBFC0_0000, fetch PC after reset.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
redirect_valid  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  32  new fetch address.
icache_req_valid  out  1  fetch request valid.
icache_req_addr  out  32  fetch address (current fetch_pc).
icache_req_ready  in  1  I-cache accepts the request this cycle.
icache_resp_valid  in  1  in-order response; cannot be back-pressured.
icache_resp_instr  in  32  fetched instruction.
icache_resp_exc  in  2  [0] ITLB refill, [1] ITLB invalid.
ID_Wr  in  1  ID consumes the head entry when IF_Valid=1.
IF_Valid  out  1  head entry present.
IF_Instr  out  32  head instruction.
IF_PC  out  32  head PC.
IF_ExceptType  out  3  [0] AdEL (misaligned PC), [1] ITLB refill, [2] ITLB invalid.

Behaviour:
- Reset (async, any time including mid-operation): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, halt=0. IF_Valid=0, IF_Instr=0, IF_PC=0, IF_ExceptType=0, icache_req_valid=0 while rst is high.
- Credit: credit_ok = (count + outstanding) < DEPTH. Outstanding counts both live and stale requests.
- Request: icache_req_valid = credit_ok & ~redirect_valid & ~halt & (fetch_pc[1:0]==0). icache_req_addr=fetch_pc.
- Accept (valid & ready): outstanding+1, fetch_pc+=4, 32-bit wrap-around.
- Response: outstanding−1.
  - drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {instr, pc, exc={resp_exc,1'b0}}. Response PCs come from a PC FIFO or a shadow counter, in request order.
  - Fetch continues after a response carrying an exception; the downstream stage redirects.
- Misaligned fetch_pc (fetch_pc[1:0]≠0, halt=0): no request. When outstanding==0 and count<DEPTH, push {instr=0, pc=fetch_pc, exc=3'b001} and set halt=1. halt clears only on redirect or reset.
- Pop: IF_Valid & ID_Wr pops the head. A same-cycle push and pop leaves count unchanged. The credit rule guarantees no push when full.
- Outputs:
  - IF_Valid=(count≠0).
  - IF_Instr/IF_PC/IF_ExceptType come from registered head storage.
  - All three are forced to 0 when empty.
  - No bypass: earliest IF_Valid is the cycle after the response.
- Redirect (highest priority):
  - Same cycle: no request is issued, any arriving response is discarded, and no push occurs.
  - Next edge: FIFO cleared; fetch_pc=redirect_pc; halt=0; drop_cnt = outstanding − (response arriving this cycle ? 1 : 0) + (drop_cnt adjustments already folded in), i.e. all still-in-flight requests become stale; outstanding is updated the same way.
  - Back-to-back redirects: the last one wins.
  - The earliest request at redirect_pc is the cycle after the redirect.
- Latency: request accepted at cycle c, response at c+k (k≥1), IF_Valid at c+k+1.

Test Plan:
1. Reset: rst=1 for 3 cycles, then released, ready=1 -> IF_Valid=0 during reset; first cycle after release icache_req_valid=1, addr=0xBFC00000.
2. Streaming: ready=1, response 1 cycle after accept with instr=~pc, ID_Wr=1 -> IF_PC=0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; IF_Instr=~IF_PC; no gaps.
3. Backpressure: ID_Wr=0, DEPTH=4 -> exactly 4 requests accepted, then icache_req_valid=0; ID_Wr=1 for one cycle -> exactly one more request; PC order preserved.
4. Stale drop: 2 outstanding, redirect_pc=0x80001000 -> both later responses discarded; IF_Valid stays 0 until the first response for 0x80001000; next IF_PC=0x80001000.
5. Misaligned: redirect_pc=0x80000002 -> no I-cache request; one entry IF_PC=0x80000002, IF_ExceptType=3'b001, IF_Instr=0; no further requests until redirect to 0x80000000 resumes fetch.
6. Cache exception plus redirect/response collision: resp_exc=2'b01 -> IF_ExceptType=3'b010, fetch continues; a response coinciding with redirect_valid is never pushed, and drop_cnt equals the remaining in-flight requests.
